// File: rtl/seg7_capture_decoder_pkg.sv
// Shared 7-segment definitions: capture FSM states and the active-low glyph table
// that both the display encoder and the readback decoder use.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} cap_state_t;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;

  // Index is the hex value, entry is the gfedcba pattern (0 = segment lit).
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    return SEG7_LUT[nibble];
  endfunction

endpackage

// File: rtl/seg7_capture_decoder_if.sv
// Capture request / result handshake bundle between a requester and the readback decoder.
interface seg7_capture_decoder_if;
  import seg7_pkg::*;

  logic [NUM_DIGITS*SEG_W-1:0] seg_i;
  logic                        capture_i;
  logic                        ready_i;
  logic [NUM_DIGITS*NIB_W-1:0] value_o;
  logic                        valid_o;
  logic [NUM_DIGITS-1:0]       err_mask_o;
  logic                        timeout_o;
  logic                        busy_o;

  modport master (
    output seg_i, capture_i, ready_i,
    input  value_o, valid_o, err_mask_o, timeout_o, busy_o
  );

  modport slave (
    input  seg_i, capture_i, ready_i,
    output value_o, valid_o, err_mask_o, timeout_o, busy_o
  );

endinterface

// File: rtl/seg7_capture_decoder_segment_decoder.sv
// One digit: active-low 7-segment pattern back to a hex nibble; unknown glyphs
// (blank included) decode to 0 and raise invalid.
module seg7_segment_decoder
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nibble,
  output logic             invalid
);

  always_comb begin
    nibble  = '0;
    invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_LUT[i]) begin
        nibble  = NIB_W'(i);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Readback monitor for the 6-digit display bus: waits for the segments to settle,
// decodes them to a 24-bit hex value and hands it over on a valid/ready handshake.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 256
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  seg7_capture_decoder_if.slave bus
);

  localparam int SEG_BITS = NUM_DIGITS * SEG_W;
  localparam int VAL_BITS = NUM_DIGITS * NIB_W;
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  localparam logic [8:0]     STAB_LAST = STABLE_CYCLES[8:0];
  localparam logic [TMO_W:0] TMO_LAST  = TIMEOUT[TMO_W:0];

  cap_state_t state, state_nxt;

  logic [SEG_BITS-1:0]   seg_q;
  logic [7:0]            stab_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [VAL_BITS-1:0]   dec_value;
  logic [NUM_DIGITS-1:0] dec_err;
  logic                  seg_same;
  logic                  stable_hit;
  logic                  tmo_hit;
  logic                  finish;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_segment_decoder u_dec (
      .seg     (seg_q[g*SEG_W +: SEG_W]),
      .nibble  (dec_value[g*NIB_W +: NIB_W]),
      .invalid (dec_err[g])
    );
  end

  // Stability wins over timeout when both land on the same edge.
  assign seg_same   = (bus.seg_i == seg_q);
  assign stable_hit = seg_same && (({1'b0, stab_cnt} + 9'd1) == STAB_LAST);
  assign tmo_hit    = (({1'b0, tmo_cnt} + 1'b1) == TMO_LAST);
  assign finish     = (state == SETTLE) && (stable_hit || tmo_hit);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.capture_i)          state_nxt = SETTLE;
      SETTLE:  if (stable_hit || tmo_hit)  state_nxt = DONE;
      DONE:    if (bus.ready_i)            state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.valid_o = (state == DONE);
    bus.busy_o  = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      seg_q    <= '0;
      stab_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.capture_i) begin
            seg_q    <= bus.seg_i;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
          end
        end
        SETTLE: begin
          seg_q    <= bus.seg_i;
          tmo_cnt  <= tmo_cnt + 1'b1;
          stab_cnt <= seg_same ? stab_cnt + 8'd1 : 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Result registers only move on completion, so they stay readable after the handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.value_o    <= '0;
      bus.err_mask_o <= '0;
      bus.timeout_o  <= 1'b0;
    end else if (finish) begin
      bus.value_o    <= dec_value;
      bus.err_mask_o <= dec_err;
      bus.timeout_o  <= !stable_hit;
    end
  end

endmodule
